fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. It owns the PC, issues requests to instruction memory over a req/ack handshake, and presents instruction plus PC+4 to the decode stage. It consumes the stall controls produced by hazard detection (PCWrite, IFIDWrite) and the branch-taken flush from decode. It buffers one instruction when decode is stalled and drains an in-flight fetch when a flush arrives.

---
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID register: owns the PC, drives the imem req/ack handshake.
// Optional FETCH_PERF_CNT_EN build adds saturating StallCycles/FlushCount counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] IFIDInstruction,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetchState_t;

  fetchState_t state, stateNext;

  logic [31:0] pc, pcNext;
  logic [31:0] pcPlus4;
  logic [31:0] bufInstr, bufInstrNext;
  logic [31:0] bufPcPlus4, bufPcPlus4Next;
  logic [31:0] drainAddr, drainAddrNext;
  logic [31:0] ifidInstrNext;
  logic [31:0] ifidPcPlus4Next;
  logic        ifidValidNext;
  logic        advance;

  // A split PCWrite/IFIDWrite is treated as a full stall.
  assign advance = PCWrite & IFIDWrite;
  assign pcPlus4 = pc + 32'd4;

  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    bufInstrNext    = bufInstr;
    bufPcPlus4Next  = bufPcPlus4;
    drainAddrNext   = drainAddr;
    ifidInstrNext   = IFIDInstruction;
    ifidPcPlus4Next = IFIDPCPlus4;
    ifidValidNext   = IFIDValid;
    IMemReq         = 1'b0;
    IMemAddr        = pc;

    case (state)
      FETCH: begin
        IMemReq  = 1'b1;
        IMemAddr = pc;
        if (IMemAck && advance) begin
          ifidInstrNext   = IMemData;
          ifidPcPlus4Next = pcPlus4;
          ifidValidNext   = 1'b1;
          pcNext          = pcPlus4;
        end else if (IMemAck) begin
          bufInstrNext   = IMemData;
          bufPcPlus4Next = pcPlus4;
          stateNext      = HOLD;
        end else if (IFIDWrite) begin
          ifidInstrNext = 32'h0000_0000;
          ifidValidNext = 1'b0;
        end
      end

      HOLD: begin
        if (advance) begin
          ifidInstrNext   = bufInstr;
          ifidPcPlus4Next = bufPcPlus4;
          ifidValidNext   = 1'b1;
          pcNext          = pcPlus4;
          stateNext       = FETCH;
        end
      end

      DRAIN: begin
        IMemReq  = 1'b1;
        IMemAddr = drainAddr;
        if (IMemAck) begin
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase

    // A redirect overrides every state action; an unacked request is completed from DRAIN.
    if (Flush) begin
      ifidInstrNext   = 32'h0000_0000;
      ifidPcPlus4Next = 32'h0000_0000;
      ifidValidNext   = 1'b0;
      pcNext          = BranchTarget;
      case (state)
        FETCH: begin
          if (IMemAck) begin
            stateNext = FETCH;
          end else begin
            drainAddrNext = pc;
            stateNext     = DRAIN;
          end
        end
        HOLD:  stateNext = FETCH;
        DRAIN: stateNext = IMemAck ? FETCH : DRAIN;
        default: stateNext = FETCH;
      endcase
    end

    if (!Reset) begin
      IMemReq = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state           <= FETCH;
      pc              <= RESET_PC;
      bufInstr        <= 32'h0000_0000;
      bufPcPlus4      <= 32'h0000_0000;
      drainAddr       <= 32'h0000_0000;
      IFIDInstruction <= 32'h0000_0000;
      IFIDPCPlus4     <= 32'h0000_0000;
      IFIDValid       <= 1'b0;
    end else begin
      state           <= stateNext;
      pc              <= pcNext;
      bufInstr        <= bufInstrNext;
      bufPcPlus4      <= bufPcPlus4Next;
      drainAddr       <= drainAddrNext;
      IFIDInstruction <= ifidInstrNext;
      IFIDPCPlus4     <= ifidPcPlus4Next;
      IFIDValid       <= ifidValidNext;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stallEvent;

  assign stallEvent = ((state == FETCH) || (state == HOLD)) && !advance;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      StallCycles <= 32'h0000_0000;
      FlushCount  <= 32'h0000_0000;
    end else begin
      if (stallEvent && (StallCycles != 32'hFFFF_FFFF)) begin
        StallCycles <= StallCycles + 32'd1;
      end
      if (Flush && (FlushCount != 32'hFFFF_FFFF)) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model returns 0x2000_0000+addr after a programmable ack delay.
module tb_fetch_unit;

  logic        Clk;
  logic        Reset;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] IFIDInstruction;
  logic [31:0] IFIDPCPlus4;
  logic        IFIDValid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;
`endif

  int checks;
  int failures;
  logic [31:0] ackDelay;
  logic [31:0] waitCnt;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .PCWrite         (PCWrite),
    .IFIDWrite       (IFIDWrite),
    .Flush           (Flush),
    .BranchTarget    (BranchTarget),
    .IMemReq         (IMemReq),
    .IMemAddr        (IMemAddr),
    .IMemAck         (IMemAck),
    .IMemData        (IMemData),
    .IFIDInstruction (IFIDInstruction),
    .IFIDPCPlus4     (IFIDPCPlus4),
    .IFIDValid       (IFIDValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .StallCycles     (StallCycles),
    .FlushCount      (FlushCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory counts how long the current request has been pending and acks once it reaches ackDelay.
  always @(posedge Clk) begin
    if (!Reset || !IMemReq || IMemAck) waitCnt <= 32'd0;
    else waitCnt <= waitCnt + 32'd1;
  end

  assign IMemAck  = IMemReq && (waitCnt >= ackDelay);
  assign IMemData = 32'h2000_0000 + IMemAddr;

  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pcw, input logic ifw, input logic fl, input logic [31:0] target);
    PCWrite      = pcw;
    IFIDWrite    = ifw;
    Flush        = fl;
    BranchTarget = target;
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expReq, input logic [31:0] expAddr,
                             input logic [31:0] expInstr, input logic [31:0] expPc4, input logic expValid);
    checkValue({tag, ".req"}, {31'd0, IMemReq}, {31'd0, expReq});
    if (expReq) checkValue({tag, ".addr"}, IMemAddr, expAddr);
    checkValue({tag, ".instr"}, IFIDInstruction, expInstr);
    checkValue({tag, ".pc4"}, IFIDPCPlus4, expPc4);
    checkValue({tag, ".valid"}, {31'd0, IFIDValid}, {31'd0, expValid});
  endtask

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    ackDelay = 32'd0;
    Reset    = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    checkOutput("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Zero-wait streaming.
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("c0", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("c1", 1'b1, 32'h4, 32'h2000_0000, 32'h4, 1'b1);
    stepCycle();
    checkOutput("c2", 1'b1, 32'h8, 32'h2000_0004, 32'h8, 1'b1);
    stepCycle();
    checkOutput("c3", 1'b1, 32'hC, 32'h2000_0008, 32'hC, 1'b1);
    stepCycle();

    // Three-cycle memory latency at 0x10.
    ackDelay = 32'd3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("c4", 1'b1, 32'h10, 32'h2000_000C, 32'h10, 1'b1);
    stepCycle();
    checkOutput("c5", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    stepCycle();
    checkOutput("c6", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    stepCycle();
    checkOutput("c7", 1'b1, 32'h10, 32'h0, 32'h10, 1'b0);
    ackDelay = 32'd0;
    stepCycle();
    checkOutput("c8", 1'b1, 32'h14, 32'h2000_0010, 32'h14, 1'b1);
    stepCycle();
    stepCycle();
    stepCycle();

    // Stall two cycles on the ack at 0x20.
    checkOutput("c11", 1'b1, 32'h20, 32'h2000_001C, 32'h20, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c12hold", 1'b0, 32'h0, 32'h2000_001C, 32'h20, 1'b1);
    stepCycle();
    checkOutput("c13hold", 1'b0, 32'h0, 32'h2000_001C, 32'h20, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c14", 1'b1, 32'h24, 32'h2000_0020, 32'h24, 1'b1);
    for (int i = 0; i < 7; i++) stepCycle();

    // Flush with the 0x40 request unacked.
    checkOutput("c21", 1'b1, 32'h40, 32'h2000_003C, 32'h40, 1'b1);
    ackDelay = 32'd2;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100);
    checkOutput("c22drain", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("c23drain", 1'b1, 32'h40, 32'h0, 32'h0, 1'b0);
    ackDelay = 32'd0;
    stepCycle();
    checkOutput("c24", 1'b1, 32'h100, 32'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("c25", 1'b1, 32'h104, 32'h2000_0100, 32'h104, 1'b1);

    // Flush wins over a full stall.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
    stepCycle();
    checkOutput("c26", 1'b1, 32'h200, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c27", 1'b1, 32'h204, 32'h2000_0200, 32'h204, 1'b1);

    // PC+4 wraps at the top of the address space.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("c28", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("c29wrap", 1'b1, 32'h0, 32'h1FFF_FFFC, 32'h0, 1'b1);

    // Second flush while draining retargets the PC but keeps the stale address on the bus.
    ackDelay = 32'd3;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
    stepCycle();
    checkOutput("c30drain", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h400);
    stepCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("c31drain", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    checkValue("flushCount", FlushCount, 32'd5);
`endif
    stepCycle();
    checkOutput("c32drain", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    ackDelay = 32'd0;
    stepCycle();
    checkOutput("c33", 1'b1, 32'h400, 32'h0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("c34", 1'b1, 32'h404, 32'h2000_0400, 32'h404, 1'b1);

    // Split stall controls behave as a stall.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c35split", 1'b0, 32'h0, 32'h2000_0400, 32'h404, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c36split", 1'b0, 32'h0, 32'h2000_0400, 32'h404, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("c37", 1'b1, 32'h408, 32'h2000_0404, 32'h408, 1'b1);

    // Reset mid-handshake, then five stall cycles from a clean start.
    ackDelay = 32'd5;
    Reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkValue("rstReq", {31'd0, IMemReq}, 32'd0);
    stepCycle();
    checkOutput("r0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    ackDelay = 32'd0;
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("s0", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) stepCycle();
    checkOutput("s5hold", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    stepCycle();
    checkOutput("s6", 1'b1, 32'h4, 32'h2000_0000, 32'h4, 1'b1);
`ifdef FETCH_PERF_CNT_EN
    checkValue("stallCycles", StallCycles, 32'd5);
    checkValue("flushCountRst", FlushCount, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
